// File: rtl/ehl_gpio_debounce.sv
// ehl_gpio_debounce: GPIO input conditioner. Each pin has a metastability
// synchroniser and an optional counter-based debounce filter. Filter length
// and sample prescaler are programmable at runtime. Each pin produces
// registered rise/fall pulses.
//
// Optional feature macro: EHL_GPIO_DEBOUNCE_IRQ_EN adds sticky per-pin
// interrupt status with rise/fall enables and write-1-to-clear. When the
// macro is undefined, irq_status and irq are tied to 0 and no interrupt
// flops exist.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   gfmr              per-pin mode (0 bypass, 1 debounce filter)
//   flt_len           filter length L (output follows after L+1 differing samples)
//   presc             sample tick every presc+1 clocks
//   data_in           raw pad inputs
//   data_out          conditioned pin values
//   rise / fall       one-cycle edge pulses, one cycle after a data_out change
//   irq_rise_en/irq_fall_en/irq_clr, irq_status, irq   optional interrupt logic

// Generic synchroniser: STAGES flops, or a wire when STAGES is 0.
module ehl_cdc #(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned STAGES     = 3,
  parameter int          TECHNOLOGY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Technology-specific sync cells would be selected here; generic flops used.
  logic unused_tech;
  assign unused_tech = TECHNOLOGY[0];

  if (STAGES == 0) begin : g_wire
    logic unused_clk;
    assign unused_clk = clk ^ rst_n;
    assign q = d;
  end else begin : g_sync
    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;

    // Shift chain: stage 0 captures d, each stage feeds the next.
    always_comb begin
      sync_d    = sync_q;
      sync_d[0] = d;
      for (int unsigned s = 1; s < STAGES; s++) begin
        sync_d[s] = sync_q[s-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];
  end

endmodule

module ehl_gpio_debounce #(
  parameter int unsigned      WIDTH          = 32,
  parameter int unsigned      CNT_W          = 4,
  parameter int unsigned      PRESC_W        = 8,
  parameter int               CDC_TECHNOLOGY = 0,
  parameter logic [WIDTH-1:0] META_ENA       = {WIDTH{1'b1}}
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   gfmr,
  input  logic [CNT_W-1:0]   flt_len,
  input  logic [PRESC_W-1:0] presc,
  input  logic [WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]   data_out,
  output logic [WIDTH-1:0]   rise,
  output logic [WIDTH-1:0]   fall,
  input  logic [WIDTH-1:0]   irq_rise_en,
  input  logic [WIDTH-1:0]   irq_fall_en,
  input  logic [WIDTH-1:0]   irq_clr,
  output logic [WIDTH-1:0]   irq_status,
  output logic               irq
);

  logic [WIDTH-1:0] dsync;

  // Per-pin synchroniser; pins with META_ENA clear are already synchronous.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_pin_sync
    ehl_cdc #(
      .WIDTH      (1),
      .STAGES     (META_ENA[i] ? 3 : 0),
      .TECHNOLOGY (CDC_TECHNOLOGY)
    ) u_cdc (
      .clk   (clk),
      .rst_n (reset_n),
      .d     (data_in[i]),
      .q     (dsync[i])
    );
  end

  // Sample prescaler; the >= compare wraps at once if presc drops below pcnt.
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic               tick_c;

  always_comb begin
    tick_c = (pcnt_q >= presc);
    pcnt_d = tick_c ? '0 : pcnt_q + PRESC_W'(1);
  end

  // Debounce filter state; bypass pins track dsync so a mode switch is glitch-free.
  logic [WIDTH-1:0]            state_q, state_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!gfmr[i]) begin
        state_d[i] = dsync[i];
        cnt_d[i]   = '0;
      end else if (tick_c) begin
        if (dsync[i] == state_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] >= flt_len) begin
          state_d[i] = dsync[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign data_out = (gfmr & state_q) | (~gfmr & dsync);

  // Edge detection against the previous cycle's data_out.
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  always_comb begin
    prev_d = data_out;
    rise_d = data_out & ~prev_q;
    fall_d = ~data_out & prev_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q  <= '0;
      state_q <= '0;
      cnt_q   <= '0;
      prev_q  <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      pcnt_q  <= pcnt_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

`ifdef EHL_GPIO_DEBOUNCE_IRQ_EN
  // Sticky pending bits; a new edge wins over a coincident clear.
  logic [WIDTH-1:0] irq_status_q, irq_status_d;

  always_comb begin
    irq_status_d = (irq_status_q & ~irq_clr)
                 | (rise_q & irq_rise_en)
                 | (fall_q & irq_fall_en);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_status_q <= '0;
    else          irq_status_q <= irq_status_d;
  end

  assign irq_status = irq_status_q;
  assign irq        = |irq_status_q;
`else
  logic unused_irq_in;
  assign unused_irq_in = ^{irq_rise_en, irq_fall_en, irq_clr};
  assign irq_status    = '0;
  assign irq           = 1'b0;
`endif

endmodule
